// File: rtl/bcd_stopwatch_gen.sv
// bcd_stopwatch_gen: N-digit BCD stopwatch / countdown timer with tick prescaler.
// Optional lap-freeze feature enabled by defining STOPWATCH_LAP_EN.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   start, stop         single-cycle pulses: begin/resume, pause
//   clear, load         single-cycle pulses: zero count, load preset (both -> STOPPED)
//   down                count direction, latched on STOPPED->RUNNING
//   preset              BCD preset, digit 0 in [3:0]; digits >9 load as 9
//   lap                 single-cycle pulse toggling the display freeze
//   count_bcd           live BCD count
//   disp_bcd            display value (live count or lap snapshot)
//   running             high while RUNNING
//   lap_active          display frozen
//   wrap                1-cycle pulse on up-count wrap (all 9s -> 0)
//   done                1-cycle pulse on down-count reaching 0
module bcd_stopwatch_gen #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic                down,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                running,
  output logic                lap_active,
  output logic                wrap,
  output logic                done
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            lap_active_q, lap_active_d;
  logic [W-1:0]    disp_q, disp_d;
  logic            running_q, running_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0]    snap_q, snap_d;
`else
  logic            unused_lap;
  assign unused_lap = lap;
`endif

  logic [W-1:0]    cnt_inc, cnt_dec, preset_sat;
  logic            carry, borrow;
  logic            all_nines;

  // Cascaded BCD increment/decrement and preset digit saturation
  always_comb begin
    carry      = 1'b1;
    borrow     = 1'b1;
    cnt_inc    = '0;
    cnt_dec    = '0;
    preset_sat = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        cnt_inc[4*i +: 4] = count_q[4*i +: 4];
      end

      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        cnt_dec[4*i +: 4] = count_q[4*i +: 4];
      end

      preset_sat[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end
    all_nines = carry;
  end

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_STOPPED;
      count_q      <= '0;
      presc_q      <= '0;
      dir_q        <= 1'b0;
      lap_active_q <= 1'b0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      snap_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      dir_q        <= dir_d;
      lap_active_q <= lap_active_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
`ifdef STOPWATCH_LAP_EN
      snap_q       <= snap_d;
`endif
    end
  end

  // Next-state and output decode; priority clear > load > stop > start > tick
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    presc_d      = presc_q;
    dir_d        = dir_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
`ifdef STOPWATCH_LAP_EN
    snap_d       = snap_q;
`endif

    if (clear) begin
      count_d      = '0;
      presc_d      = '0;
      lap_active_d = 1'b0;
      state_d      = ST_STOPPED;
    end else if (load) begin
      count_d = preset_sat;
      presc_d = '0;
      state_d = ST_STOPPED;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          // A down count cannot start from zero
          if (start && !stop && !(down && (count_q == '0))) begin
            state_d = ST_RUNNING;
            dir_d   = down;
          end
        end
        ST_RUNNING: begin
          if (stop) begin
            state_d = ST_STOPPED;
          end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            if (dir_q) begin
              count_d = cnt_dec;
              if (count_q == W'(1)) begin
                done_d  = 1'b1;
                state_d = ST_EXPIRED;
              end
            end else begin
              count_d = cnt_inc;
              wrap_d  = all_nines;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_STOPPED;
        end
      endcase
    end

`ifdef STOPWATCH_LAP_EN
    // Lap toggles the freeze; snapshot is the count before this edge's update
    if (lap && !clear) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else begin
        lap_active_d = 1'b1;
        snap_d       = count_q;
      end
    end
    disp_d = lap_active_d ? snap_d : count_d;
`else
    lap_active_d = 1'b0;
    disp_d       = count_d;
`endif

    running_d = (state_d == ST_RUNNING);
  end

  assign count_bcd  = count_q;
  assign disp_bcd   = disp_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bcd_stopwatch_gen.sv
// Self-checking bench for bcd_stopwatch_gen (DIGITS=2, TICK_DIV=4):
// directed scenarios with literal expectations, then randomized pulses,
// all checked every cycle against an integer-arithmetic reference model.
module tb_bcd_stopwatch_gen;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned W        = 4 * DIGITS;
  localparam int          MAXV     = 100;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, clear, load, down, lap;
  logic [W-1:0] preset;
  logic [W-1:0] count_bcd, disp_bcd;
  logic         running, lap_active, wrap, done;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  bcd_stopwatch_gen #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .down(down), .preset(preset), .lap(lap),
    .count_bcd(count_bcd), .disp_bcd(disp_bcd), .running(running),
    .lap_active(lap_active), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // Model: count as a plain integer, mode 0=stopped 1=running 2=expired
  int m_cnt, m_presc, m_mode, m_snap;
  bit m_dir, m_lap, m_wrap, m_done;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int preset_val(input logic [W-1:0] p);
    int v, scale, d;
    v = 0;
    scale = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    int old;
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_mode = 0; m_dir = 1'b0; m_lap = 1'b0; m_snap = 0;
    end else begin
      old = m_cnt;
      if (clear) begin
        m_cnt = 0; m_presc = 0; m_mode = 0; m_lap = 1'b0;
      end else if (load) begin
        m_cnt = preset_val(preset); m_presc = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (start && !stop && !(down && m_cnt == 0)) begin
          m_mode = 1; m_dir = down;
        end
      end else if (m_mode == 1) begin
        if (stop) begin
          m_mode = 0;
        end else begin
          m_presc = m_presc + 1;
          if (m_presc == TICK_DIV) begin
            m_presc = 0;
            if (m_dir) begin
              m_cnt = m_cnt - 1;
              if (m_cnt == 0) begin
                m_done = 1'b1; m_mode = 2;
              end
            end else begin
              m_cnt  = (m_cnt + 1) % MAXV;
              m_wrap = (m_cnt == 0);
            end
          end
        end
      end
`ifdef STOPWATCH_LAP_EN
      if (lap && !clear) begin
        if (m_lap) m_lap = 1'b0;
        else begin
          m_lap = 1'b1; m_snap = old;
        end
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
      chk("m_disp", 32'(disp_bcd), 32'(to_bcd(m_lap ? m_snap : m_cnt)));
      chk("m_running", 32'(running), 32'(m_mode == 1));
      chk("m_lap_active", 32'(lap_active), 32'(m_lap));
      chk("m_wrap", 32'(wrap), 32'(m_wrap));
      chk("m_done", 32'(done), 32'(m_done));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    down = 1'b0; lap = 1'b0; preset = '0;

    // Reset
    cyc(2);
    check_en = 1'b1;
    chk("rst_count", 32'(count_bcd), 32'h00);
    chk("rst_disp", 32'(disp_bcd), 32'h00);
    chk("rst_running", 32'(running), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // Basic run
    start = 1'b1; cyc(1); start = 1'b0;
    chk("run_running", 32'(running), 32'h1);
    cyc(3);
    chk("run_before_tick", 32'(count_bcd), 32'h00);
    cyc(1);
    chk("run_tick1", 32'(count_bcd), 32'h01);
    cyc(4);
    chk("run_tick2", 32'(count_bcd), 32'h02);

    // Up wrap
    preset = 8'h98; load = 1'b1; cyc(1); load = 1'b0;
    chk("wrap_load", 32'(count_bcd), 32'h98);
    chk("wrap_load_stopped", 32'(running), 32'h0);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("wrap_99", 32'(count_bcd), 32'h99);
    cyc(4);
    chk("wrap_00", 32'(count_bcd), 32'h00);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    cyc(1);
    chk("wrap_pulse_end", 32'(wrap), 32'h0);

    // Down expiry
    preset = 8'h10; load = 1'b1; cyc(1); load = 1'b0;
    down = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("down_09", 32'(count_bcd), 32'h09);
    cyc(32);
    chk("down_01", 32'(count_bcd), 32'h01);
    cyc(4);
    chk("down_00", 32'(count_bcd), 32'h00);
    chk("down_done", 32'(done), 32'h1);
    chk("down_stopped", 32'(running), 32'h0);
    cyc(1);
    chk("down_done_end", 32'(done), 32'h0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("expired_start_ign", 32'(running), 32'h0);
    down = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    chk("expired_start_up_ign", 32'(running), 32'h0);
    cyc(8);
    chk("expired_hold", 32'(count_bcd), 32'h00);

    // Pause / resume: stop freezes the prescaler at 2, so resume ticks 2 cycles later
    preset = 8'h00; load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("pause_tick", 32'(count_bcd), 32'h01);
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("pause_stopped", 32'(running), 32'h0);
    cyc(10);
    chk("pause_hold", 32'(count_bcd), 32'h01);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    chk("resume_not_yet", 32'(count_bcd), 32'h01);
    cyc(1);
    chk("resume_tick", 32'(count_bcd), 32'h02);
    stop = 1'b1; cyc(1); stop = 1'b0;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    chk("start_stop_same", 32'(running), 32'h0);
    preset = 8'h45; clear = 1'b1; load = 1'b1; cyc(1); clear = 1'b0; load = 1'b0;
    chk("clear_over_load", 32'(count_bcd), 32'h00);

    // Lap freeze
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(20);
    chk("lap_at5", 32'(count_bcd), 32'h05);
    lap = 1'b1; cyc(1); lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    chk("lap_frozen", 32'(disp_bcd), 32'h05);
    chk("lap_active_on", 32'(lap_active), 32'h1);
`else
    chk("lap_ignored", 32'(lap_active), 32'h0);
`endif
    cyc(11);
    chk("lap_count8", 32'(count_bcd), 32'h08);
`ifdef STOPWATCH_LAP_EN
    chk("lap_still_frozen", 32'(disp_bcd), 32'h05);
`else
    chk("lap_disp_live", 32'(disp_bcd), 32'h08);
`endif
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_release", 32'(disp_bcd), 32'h08);
    chk("lap_active_off", 32'(lap_active), 32'h0);

    // Invalid preset saturation and mid-run reset
    preset = 8'hA3; load = 1'b1; cyc(1); load = 1'b0;
    chk("sat_load", 32'(count_bcd), 32'h93);
    chk("sat_disp", 32'(disp_bcd), 32'h93);
    start = 1'b1; cyc(1); start = 1'b0;
    lap = 1'b1; cyc(1); lap = 1'b0;
    cyc(5);
    rst_n = 1'b0; start = 1'b1; load = 1'b1; cyc(1);
    start = 1'b0; load = 1'b0;
    chk("mrst_count", 32'(count_bcd), 32'h00);
    chk("mrst_disp", 32'(disp_bcd), 32'h00);
    chk("mrst_running", 32'(running), 32'h0);
    chk("mrst_lap", 32'(lap_active), 32'h0);
    rst_n = 1'b1;

    // Randomized pulses; model comparison runs every cycle
    for (int n = 0; n < 4000; n++) begin
      rst_n  = ($urandom_range(0, 399) != 0);
      clear  = ($urandom_range(0, 119) == 0);
      load   = ($urandom_range(0, 49) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 7) == 0);
      lap    = ($urandom_range(0, 24) == 0);
      down   = $urandom_range(0, 1) == 1;
      preset = 8'($urandom);
      cyc(1);
    end
    rst_n = 1'b1; clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_gen.md
Name: bcd_stopwatch_gen

Overview:
Parametrised BCD stopwatch/countdown timer with N digits and an internal tick prescaler. Everything runs in the single system clock domain; there is no derived clock.
It adds several behaviours to the basic 4-digit stopwatch: count direction, preset load, terminal-zero expiry, wrap flag and lap hold.
It sits between the debounced button pulses and the multi-digit 7-segment controller, which consumes disp_bcd.

Parameters:
DIGITS, 4, number of BCD digits (1..8)
TICK_DIV, 100000, clk cycles per count tick (>=2); 100 MHz / 100000 = 1 kHz

Ports:
clk  in  1  system clock; all logic on posedge clk
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begin/resume counting
stop  in  1  single-cycle pulse; pause counting
clear  in  1  single-cycle pulse; count to zero, return to STOPPED
load  in  1  single-cycle pulse; count <= preset, return to STOPPED
down  in  1  direction (1 = count down); latched only on STOPPED->RUNNING
preset  in  4*DIGITS  BCD preset value, digit 0 in [3:0]
lap  in  1  single-cycle pulse; toggle display freeze
count_bcd  out  4*DIGITS  live BCD count
disp_bcd  out  4*DIGITS  display value (count_bcd or lap snapshot)
running  out  1  high in RUNNING
lap_active  out  1  display frozen
wrap  out  1  1-cycle pulse on up-count wrap (all 9s -> 0)
done  out  1  1-cycle pulse on down-count reaching 0

Behaviour:
- Reset (rst_n=0 at posedge): state=STOPPED, count=0, prescaler=0, dir_q=0, lap_active=0, disp_bcd=0, running=0, wrap=0, done=0.
- States:
  - STOPPED: start -> RUNNING, and dir_q<=down. Exception: start is ignored when down=1 and count==0.
  - RUNNING: stop -> STOPPED. A down tick from count 1 -> EXPIRED.
  - EXPIRED: count held at 0. Only clear/load leave it (-> STOPPED). start/stop ignored.
- Priority per cycle, highest first: clear > load > stop > start > tick. start and stop together: stop wins.
- clear: count=0, prescaler=0, lap_active=0, state=STOPPED, next cycle.
- load: count=preset, prescaler=0, lap_active unchanged. Any preset digit >9 is loaded as 9.
- Prescaler:
  - Increments only in RUNNING; wraps at TICK_DIV-1.
  - tick = RUNNING && prescaler==TICK_DIV-1.
  - Held, not reset, in STOPPED, so resume preserves the partial period.
- Tick timing: count updates on the same edge as the prescaler wrap. The first tick occurs TICK_DIV cycles after entering RUNNING from prescaler=0.
- Up count (dir_q=0):
  - Cascaded BCD increment; a digit carries only when all lower digits are 9.
  - All 9s -> all 0s, with wrap=1 for exactly that cycle; remains RUNNING.
- Down count (dir_q=1):
  - Cascaded BCD decrement; a digit borrows only when all lower digits are 0.
  - Reaching 0: done=1 for one cycle, state=EXPIRED, running=0 in the same cycle.
- down changes while RUNNING have no effect.
- running is a registered decode of the state; it is high the cycle after the start edge.
- wrap and done are registered pulses, never held longer than one cycle.
- Mid-count reset: rst_n=0 overrides all inputs. Everything returns to reset values next edge, including an in-progress lap freeze.
- disp_bcd is registered: it equals count_bcd (one-cycle-aligned, same register update) when lap_active=0.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - lap with lap_active=0 snapshots count_bcd into the lap register and sets lap_active. disp_bcd shows the snapshot while counting continues.
  - lap with lap_active=1 clears lap_active; disp_bcd follows count_bcd again.
  - clear also releases lap_active. lap in the same cycle as clear is ignored.
- Undefined: the lap input is unused, lap_active tied 0, disp_bcd == count_bcd, no snapshot register.

Test Plan:
1. Reset/run: DIGITS=2, TICK_DIV=4; rst_n low 2 cycles, then start -> running=1 next cycle; count_bcd=0x01 after 4 cycles, 0x02 after 8.
2. Up wrap: load preset=0x98, start -> ticks give 0x99, then 0x00 with wrap=1 for exactly one cycle; running stays 1.
3. Down expiry: load 0x10, down=1, start -> 0x09, 0x08 ... 0x01, 0x00. done pulses one cycle at 0x00, running=0; later start is ignored, count stays 0x00.
4. Pause/resume/priority: stop 2 cycles after a tick, wait 10 cycles, start -> next tick arrives 2 cycles after resume. start+stop same cycle -> remains STOPPED. clear+load same cycle -> count=0x00.
5. Lap (with STOPWATCH_LAP_EN): at count 0x05, lap -> disp_bcd=0x05 while count_bcd reaches 0x08; lap again -> disp_bcd=0x08. Without the macro, disp_bcd always equals count_bcd.
6. Invalid preset/reset mid-run: preset=0xA3 loads 0x93. Asserting rst_n=0 while RUNNING with lap_active=1 -> all outputs 0 on the next edge.
